// File: rtl/warp_pkg.sv
// Shared encodings for the warp load/store unit: access widths, ops, AHB transfer
// types, response causes and LSU FSM states.
package warp_pkg;

    localparam logic [1:0] WIDTH_BYTE   = 2'b00;
    localparam logic [1:0] WIDTH_HALF   = 2'b01;
    localparam logic [1:0] WIDTH_WORD   = 2'b10;
    localparam logic [1:0] WIDTH_DOUBLE = 2'b11;

    localparam logic LSU_OP_READ  = 1'b0;
    localparam logic LSU_OP_WRITE = 1'b1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        CAUSE_OK         = 2'd0,
        CAUSE_MISALIGNED = 2'd1,
        CAUSE_RANGE      = 2'd2,
        CAUSE_BUS_ERR    = 2'd3
    } lsu_cause_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FAULT = 3'd4
    } lsu_state_e;

    // Byte-lane mask of an access before it is shifted to its address offset.
    function automatic logic [7:0] width_mask(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: width_mask = 8'h01;
            WIDTH_HALF: width_mask = 8'h03;
            WIDTH_WORD: width_mask = 8'h0F;
            default:    width_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/warp_lsu_align.sv
// Lane steering between the right-justified LSU view and the 64-bit AHB data bus:
// store replication/strobes and load shift/extension.
module warp_lsu_align
    import warp_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [2:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] hrdata,
    output logic [63:0] hwdata,
    output logic [7:0]  hwstrb,
    output logic [63:0] rdata
);

    logic [63:0] shifted;

    // Replicate the store value so every lane at the access width carries it.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign hwdata[8*gi +: 8] =
                (width == WIDTH_BYTE) ? wdata[7:0] :
                (width == WIDTH_HALF) ? wdata[8*(gi%2) +: 8] :
                (width == WIDTH_WORD) ? wdata[8*(gi%4) +: 8] :
                                        wdata[8*gi +: 8];
        end
    endgenerate

    assign hwstrb  = width_mask(width) << addr_lo;
    assign shifted = hrdata >> {addr_lo, 3'b000};

    always_comb begin
        rdata = shifted;
        case (width)
            WIDTH_BYTE: rdata = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
            WIDTH_HALF: rdata = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
            WIDTH_WORD: rdata = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
            default:    rdata = shifted;
        endcase
    end

endmodule

// File: rtl/warp_lsu_ahb.sv
// Single-outstanding load/store unit issuing one AHB5-lite transfer per request,
// with alignment/range fault checks and lane-steered, extended load data.
module warp_lsu_ahb
    import warp_pkg::*;
#(
    parameter int         AW    = 34,
    parameter int         OFF_W = 32,
    parameter logic [3:0] HPROT = 4'b0011
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_opsel,
    input  logic [63:0]       i_base,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [1:0]        i_width,
    input  logic              i_unsigned,
    input  logic [63:0]       i_wdata,
    output logic              o_rsp_valid,
    output logic [1:0]        o_rsp_cause,
    output logic [63:0]       o_rsp_rdata,
    output logic [AW-1:0]     o_ahb_haddr,
    output logic [1:0]        o_ahb_htrans,
    output logic [2:0]        o_ahb_hsize,
    output logic [2:0]        o_ahb_hburst,
    output logic [3:0]        o_ahb_hprot,
    output logic              o_ahb_hmastlock,
    output logic              o_ahb_hwrite,
    output logic [63:0]       o_ahb_hwdata,
    output logic [7:0]        o_ahb_hwstrb,
    input  logic [63:0]       i_ahb_hrdata,
    input  logic              i_ahb_hready,
    input  logic              i_ahb_hresp
);

    lsu_state_e  state_reg;
    lsu_cause_e  fault_cause;
    lsu_cause_e  rsp_cause_reg;
    logic [63:0] ea_next;
    logic        misaligned;
    logic        out_of_range;
    logic        accept;

    logic        op_reg;
    logic [1:0]  width_reg;
    logic        unsigned_reg;
    logic [2:0]  addr_lo_reg;
    logic [63:0] wdata_reg;

    logic [AW-1:0] haddr_reg;
    logic [1:0]    htrans_reg;
    logic [2:0]    hsize_reg;
    logic          hwrite_reg;
    logic [63:0]   hwdata_reg;
    logic [7:0]    hwstrb_reg;
    logic          rsp_valid_reg;
    logic [63:0]   rsp_rdata_reg;

    logic [63:0] st_hwdata;
    logic [7:0]  st_hwstrb;
    logic [63:0] ld_rdata;

    assign ea_next = i_base + {{(64-OFF_W){i_offset[OFF_W-1]}}, i_offset};

    always_comb begin
        case (i_width)
            WIDTH_HALF:   misaligned = ea_next[0];
            WIDTH_WORD:   misaligned = |ea_next[1:0];
            WIDTH_DOUBLE: misaligned = |ea_next[2:0];
            default:      misaligned = 1'b0;
        endcase
        out_of_range = |ea_next[63:AW];
        fault_cause  = CAUSE_OK;
        if (misaligned)
            fault_cause = CAUSE_MISALIGNED;
        else if (out_of_range)
            fault_cause = CAUSE_RANGE;
    end

    // Response states accept like IDLE so a new request can overlap the response pulse.
    assign o_req_ready = (state_reg != ST_ADDR) && (state_reg != ST_DATA);
    assign accept      = i_req_valid & o_req_ready;

    warp_lsu_align u_align (
        .width       (width_reg),
        .addr_lo     (addr_lo_reg),
        .is_unsigned (unsigned_reg),
        .wdata       (wdata_reg),
        .hrdata      (i_ahb_hrdata),
        .hwdata      (st_hwdata),
        .hwstrb      (st_hwstrb),
        .rdata       (ld_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= LSU_OP_READ;
            width_reg     <= WIDTH_BYTE;
            unsigned_reg  <= 1'b0;
            addr_lo_reg   <= '0;
            wdata_reg     <= '0;
            haddr_reg     <= '0;
            htrans_reg    <= HTRANS_IDLE;
            hsize_reg     <= '0;
            hwrite_reg    <= 1'b0;
            hwdata_reg    <= '0;
            hwstrb_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_cause_reg <= CAUSE_OK;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_cause_reg <= CAUSE_OK;
            rsp_rdata_reg <= '0;
            case (state_reg)
                ST_IDLE, ST_RESP, ST_FAULT: begin
                    state_reg <= ST_IDLE;
                    if (accept) begin
                        op_reg       <= i_opsel;
                        width_reg    <= i_width;
                        unsigned_reg <= i_unsigned;
                        addr_lo_reg  <= ea_next[2:0];
                        wdata_reg    <= i_wdata;
                        if (fault_cause != CAUSE_OK) begin
                            state_reg     <= ST_FAULT;
                            rsp_valid_reg <= 1'b1;
                            rsp_cause_reg <= fault_cause;
                        end else begin
                            state_reg  <= ST_ADDR;
                            htrans_reg <= HTRANS_NONSEQ;
                            haddr_reg  <= ea_next[AW-1:0];
                            hsize_reg  <= {1'b0, i_width};
                            hwrite_reg <= i_opsel;
                        end
                    end
                end
                ST_ADDR: begin
                    if (i_ahb_hready) begin
                        state_reg  <= ST_DATA;
                        htrans_reg <= HTRANS_IDLE;
                        hwdata_reg <= st_hwdata;
                        hwstrb_reg <= st_hwstrb;
                    end
                end
                ST_DATA: begin
                    if (i_ahb_hready) begin
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                        if (i_ahb_hresp)
                            rsp_cause_reg <= CAUSE_BUS_ERR;
                        else if (op_reg == LSU_OP_READ)
                            rsp_rdata_reg <= ld_rdata;
                        haddr_reg  <= '0;
                        hsize_reg  <= '0;
                        hwrite_reg <= 1'b0;
                        hwdata_reg <= '0;
                        hwstrb_reg <= '0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_rsp_valid     = rsp_valid_reg;
    assign o_rsp_cause     = rsp_cause_reg;
    assign o_rsp_rdata     = rsp_rdata_reg;
    assign o_ahb_haddr     = haddr_reg;
    assign o_ahb_htrans    = htrans_reg;
    assign o_ahb_hsize     = hsize_reg;
    assign o_ahb_hburst    = 3'b000;
    assign o_ahb_hprot     = HPROT;
    assign o_ahb_hmastlock = 1'b0;
    assign o_ahb_hwrite    = hwrite_reg;
    assign o_ahb_hwdata    = hwdata_reg;
    assign o_ahb_hwstrb    = hwstrb_reg;

endmodule
